// File: rtl/int_iq_slot_alloc_ctrl_pkg.sv
// Shared integer issue-queue constants: slot geometry, flush FSM encoding and
// the slot set the free list holds after a re-initialise.
package int_iq_slot_alloc_ctrl_pkg;

   localparam int SLOTW      = 5;
   localparam int SLOTNUM    = 8;
   localparam int SETTLE_CYC = 2;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_CLEAN  = 2'd1,
      ST_SETTLE = 2'd2
   } iq_state_e;

   localparam logic [SLOTW-1:0] FL_RST_SLOT [SLOTNUM] = '{
      5'd2, 5'd6, 5'd10, 5'd14, 5'd18, 5'd22, 5'd26, 5'd30
   };

endpackage

// File: rtl/int_iq_slot_alloc_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter; grant is combinational, pointer updates on the edge.
// Priority flips to the other requester after every grant; en=0 suppresses grant and update.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   logic ptr_q, ptr_d;

   always_comb begin
      gnt = 2'b00;
      if (en) begin
         if (req == 2'b11) gnt = ptr_q ? 2'b10 : 2'b01;
         else              gnt = req;
      end
      ptr_d = ptr_q;
      if (gnt[0])      ptr_d = 1'b1;
      else if (gnt[1]) ptr_d = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) ptr_q <= 1'b0;
      else     ptr_q <= ptr_d;
   end

endmodule

// File: rtl/int_iq_slot_alloc_ctrl.sv
// Int IQ slot allocation: zero-latency grant from the free-list head, releases held one deep per
// port and merged onto one push. Releases are refused while a port's buffer stays full or outside RUN.
module int_iq_slot_alloc_ctrl
   import int_iq_slot_alloc_ctrl_pkg::*;
(
   input  logic             Clk,
   input  logic             Rest,
   input  logic             DispReq,
   output logic             DispGnt,
   output logic [SLOTW-1:0] DispSlot,
   input  logic [1:0]       RelValid,
   input  logic [SLOTW-1:0] RelSlot0,
   input  logic [SLOTW-1:0] RelSlot1,
   output logic [1:0]       RelReady,
   input  logic             FlushReq,
   output logic             FlRable,
   output logic             FlWable,
   output logic [SLOTW-1:0] FlDin,
   output logic             FlClean,
   input  logic [SLOTW-1:0] FlPreOut,
   input  logic             FlEmpty,
   output logic [3:0]       AllocCnt,
   output logic             RelErr
);

   localparam int             STW         = $clog2(SETTLE_CYC + 1);
   localparam logic [STW-1:0] SETTLE_LAST = STW'(SETTLE_CYC - 1);

   iq_state_e        state_q;
   logic [STW-1:0]   settle_cnt_q;
   logic             fl_clean_q;
   logic [1:0]       buf_vld_q, buf_vld_d;
   logic [SLOTW-1:0] buf_dat_q [2];
   logic [SLOTW-1:0] buf_dat_d [2];
   logic [3:0]       alloc_cnt_q, alloc_cnt_d;
   logic             rel_err_q, rel_err_d;
   logic             run, disp_gnt, push_ok, fl_push, rel_drop;
   logic [1:0]       arb_gnt, rel_rdy;
   logic [SLOTW-1:0] rel_slot [2];
   logic [SLOTW-1:0] win_slot;

   assign rel_slot[0] = RelSlot0;
   assign rel_slot[1] = RelSlot1;

   rr_arb2 u_arb (
      .clk (Clk),
      .rst (Rest),
      .en  (~FlushReq),
      .req (buf_vld_q),
      .gnt (arb_gnt)
   );

   always_comb begin
      run      = (state_q == ST_RUN);
      disp_gnt = DispReq & run & ~FlEmpty & ~FlushReq & ~Rest;
      win_slot = arb_gnt[1] ? buf_dat_q[1] : buf_dat_q[0];
      // A push needs an outstanding slot to return, counting this cycle's grant.
      push_ok  = (alloc_cnt_q != 4'd0) | disp_gnt;
      fl_push  = (|arb_gnt) & push_ok;
      rel_drop = (|arb_gnt) & ~push_ok;

      for (int i = 0; i < 2; i++)
         rel_rdy[i] = run & ~FlushReq & ~Rest & (~buf_vld_q[i] | arb_gnt[i]);

      buf_vld_d = buf_vld_q;
      buf_dat_d = buf_dat_q;
      for (int i = 0; i < 2; i++) begin
         if (FlushReq) begin
            buf_vld_d[i] = 1'b0;
         end else if (RelValid[i] & rel_rdy[i]) begin
            buf_vld_d[i] = 1'b1;
            buf_dat_d[i] = rel_slot[i];
         end else if (arb_gnt[i]) begin
            buf_vld_d[i] = 1'b0;
         end
      end

      alloc_cnt_d = alloc_cnt_q;
      if (FlushReq)                alloc_cnt_d = 4'd0;
      else if (disp_gnt & ~fl_push) alloc_cnt_d = alloc_cnt_q + 4'd1;
      else if (~disp_gnt & fl_push) alloc_cnt_d = alloc_cnt_q - 4'd1;

      rel_err_d = rel_err_q | rel_drop;
   end

   always_ff @(posedge Clk or posedge Rest) begin
      if (Rest) begin
         buf_vld_q    <= 2'b00;
         buf_dat_q[0] <= '0;
         buf_dat_q[1] <= '0;
         alloc_cnt_q  <= 4'd0;
         rel_err_q    <= 1'b0;
      end else begin
         buf_vld_q   <= buf_vld_d;
         buf_dat_q   <= buf_dat_d;
         alloc_cnt_q <= alloc_cnt_d;
         rel_err_q   <= rel_err_d;
      end
   end

   // A flush in any state (re)starts the clean; FlClean is high for exactly the CLEAN cycles.
   always_ff @(posedge Clk or posedge Rest) begin
      if (Rest) begin
         state_q      <= ST_RUN;
         settle_cnt_q <= '0;
         fl_clean_q   <= 1'b0;
      end else begin
         fl_clean_q <= 1'b0;
         if (FlushReq) begin
            state_q      <= ST_CLEAN;
            settle_cnt_q <= '0;
            fl_clean_q   <= 1'b1;
         end else begin
            case (state_q)
               ST_CLEAN: begin
                  state_q      <= ST_SETTLE;
                  settle_cnt_q <= '0;
               end
               ST_SETTLE: begin
                  if (settle_cnt_q == SETTLE_LAST) state_q <= ST_RUN;
                  else                             settle_cnt_q <= settle_cnt_q + 1'b1;
               end
               ST_RUN:  ;
               default: state_q <= ST_RUN;
            endcase
         end
      end
   end

   assign DispGnt  = disp_gnt;
   assign DispSlot = FlPreOut;
   assign FlRable  = disp_gnt;
   assign FlWable  = fl_push;
   assign FlDin    = win_slot;
   assign FlClean  = fl_clean_q;
   assign RelReady = rel_rdy;
   assign AllocCnt = alloc_cnt_q;
   assign RelErr   = rel_err_q;

endmodule

// File: tb/tb_int_iq_slot_alloc_ctrl.sv
// Closed-loop bench: emulates the slot free list and checks every output each cycle
// against a transaction-level model of grants, held releases and the flush blackout.
module tb_int_iq_slot_alloc_ctrl;

   logic       Clk = 1'b0;
   logic       Rest, DispReq, FlushReq, FlEmpty;
   logic       DispGnt, FlRable, FlWable, FlClean, RelErr;
   logic [4:0] DispSlot, RelSlot0, RelSlot1, FlDin, FlPreOut;
   logic [1:0] RelValid, RelReady;
   logic [3:0] AllocCnt;

   always #5 Clk = ~Clk;

   int_iq_slot_alloc_ctrl dut (
      .Clk(Clk), .Rest(Rest), .DispReq(DispReq), .DispGnt(DispGnt), .DispSlot(DispSlot),
      .RelValid(RelValid), .RelSlot0(RelSlot0), .RelSlot1(RelSlot1), .RelReady(RelReady),
      .FlushReq(FlushReq), .FlRable(FlRable), .FlWable(FlWable), .FlDin(FlDin),
      .FlClean(FlClean), .FlPreOut(FlPreOut), .FlEmpty(FlEmpty), .AllocCnt(AllocCnt),
      .RelErr(RelErr)
   );

   int n_chk = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Reference model: free-list contents, slots outstanding, pending release per port
   // (-1 = none), port favoured on a tie, sticky error, cycles left with dispatch blocked.
   logic [4:0] fl_q[$];
   int         m_cnt;
   int         m_buf[2];
   int         m_fav;
   bit         m_err;
   int         m_blk;
   bit         m_last_gnt;

   task automatic fl_restore();
      fl_q.delete();
      for (int k = 0; k < 8; k++) fl_q.push_back(5'(4 * k + 2));
   endtask

   task automatic model_reset();
      fl_restore();
      m_cnt = 0; m_buf[0] = -1; m_buf[1] = -1;
      m_fav = 0; m_err = 0; m_blk = 0; m_last_gnt = 0;
   endtask

   task automatic cycle();
      bit run, clean, gnt, push;
      bit [1:0] rdy;
      int win;
      int rel[2];
      logic [4:0] din;
      FlPreOut = (fl_q.size() > 0) ? fl_q[0] : 5'd0;
      FlEmpty  = (fl_q.size() == 0);
      @(negedge Clk);
      run   = (m_blk == 0);
      clean = (m_blk == 3);
      gnt   = DispReq && run && fl_q.size() > 0 && !FlushReq;
      win   = -1;
      if (!FlushReq) begin
         if (m_buf[0] >= 0 && m_buf[1] >= 0) win = m_fav;
         else if (m_buf[0] >= 0)             win = 0;
         else if (m_buf[1] >= 0)             win = 1;
      end
      push = (win >= 0) && (m_cnt + int'(gnt) > 0);
      din  = (win >= 0) ? 5'(m_buf[win]) : 5'd0;
      for (int i = 0; i < 2; i++) rdy[i] = run && !FlushReq && (m_buf[i] < 0 || win == i);

      chk("disp_gnt", DispGnt, gnt);
      chk("fl_rable", FlRable, gnt);
      if (gnt) chk("disp_slot", DispSlot, fl_q[0]);
      chk("rel_ready", RelReady, rdy);
      chk("fl_wable", FlWable, push);
      if (push) chk("fl_din", FlDin, din);
      chk("fl_clean", FlClean, clean);
      chk("alloc_cnt", AllocCnt, m_cnt);
      chk("rel_err", RelErr, m_err);

      rel[0] = RelSlot0; rel[1] = RelSlot1;
      if (FlushReq) begin
         m_buf[0] = -1; m_buf[1] = -1; m_cnt = 0; m_blk = 3;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (RelValid[i] && rdy[i]) m_buf[i] = rel[i];
            else if (win == i)         m_buf[i] = -1;
         end
         m_cnt = m_cnt + int'(gnt) - int'(push);
         if (m_blk > 0) m_blk--;
      end
      if (win >= 0) begin
         m_fav = 1 - win;
         if (!push) m_err = 1;
      end
      if (gnt)  void'(fl_q.pop_front());
      if (push) fl_q.push_back(din);
      if (clean) fl_restore();
      m_last_gnt = gnt;
      @(posedge Clk);
      #1;
   endtask

   task automatic rel_one(input int port, input logic [4:0] slot);
      RelValid = 2'b01 << port;
      if (port == 0) RelSlot0 = slot; else RelSlot1 = slot;
      cycle();
      RelValid = 2'b00;
   endtask

   initial begin
      logic [4:0] rel_tbl [6];
      rel_tbl = '{5'd2, 5'd10, 5'd18, 5'd22, 5'd26, 5'd30};
      Rest = 1'b1; DispReq = 1'b1; RelValid = 2'b00; RelSlot0 = '0; RelSlot1 = '0;
      FlushReq = 1'b0; FlPreOut = 5'd2; FlEmpty = 1'b0;
      repeat (2) @(posedge Clk);
      @(negedge Clk);
      chk("rst_disp_gnt", DispGnt, 0);
      chk("rst_alloc_cnt", AllocCnt, 0);
      chk("rst_rel_err", RelErr, 0);
      chk("rst_fl_clean", FlClean, 0);
      chk("rst_fl_wable", FlWable, 0);
      chk("rst_rel_ready", RelReady, 0);
      Rest = 1'b0; DispReq = 1'b0;
      model_reset();
      @(posedge Clk); #1;

      // Drain the whole free list, then one more request against an empty list.
      DispReq = 1'b1;
      repeat (9) cycle();
      DispReq = 1'b0;

      // Return six slots one at a time, then two at once on both ports.
      for (int k = 0; k < 6; k++) rel_one(k % 2, rel_tbl[k]);
      cycle();
      RelValid = 2'b11; RelSlot0 = 5'd6; RelSlot1 = 5'd14;
      cycle();
      RelValid = 2'b00;
      repeat (3) cycle();

      // Sustained releases on both ports while dispatch keeps slots outstanding.
      DispReq = 1'b1; RelValid = 2'b11;
      for (int k = 0; k < 8; k++) begin
         RelSlot0 = 5'(k); RelSlot1 = 5'(k + 16);
         cycle();
      end
      RelValid = 2'b00;
      repeat (2) cycle();
      DispReq = 1'b0;
      cycle();
      while (m_cnt > 0) rel_one(0, 5'd1);
      repeat (2) cycle();

      // Release with nothing outstanding: dropped and flagged sticky.
      rel_one(0, 5'd10);
      repeat (4) cycle();

      // Flush with a held release and five slots outstanding.
      DispReq = 1'b1;
      repeat (5) cycle();
      DispReq = 1'b0;
      rel_one(1, 5'd9);
      FlushReq = 1'b1;
      cycle();
      FlushReq = 1'b0; DispReq = 1'b1;
      repeat (5) cycle();

      // Asynchronous reset in the middle of the settle window.
      DispReq = 1'b0; FlushReq = 1'b1;
      cycle();
      FlushReq = 1'b0;
      cycle();
      DispReq = 1'b1; RelValid = 2'b11;
      #1 Rest = 1'b1;
      #1;
      chk("arst_disp_gnt", DispGnt, 0);
      chk("arst_fl_rable", FlRable, 0);
      chk("arst_fl_wable", FlWable, 0);
      chk("arst_fl_clean", FlClean, 0);
      chk("arst_alloc_cnt", AllocCnt, 0);
      chk("arst_rel_err", RelErr, 0);
      chk("arst_rel_ready", RelReady, 0);
      #1 Rest = 1'b0;
      model_reset();
      cycle();
      RelValid = 2'b00;

      // Randomised traffic, with one reset part way through.
      for (int n = 0; n < 3000; n++) begin
         if (n == 1500) begin
            Rest = 1'b1;
            @(posedge Clk); #1;
            Rest = 1'b0;
            model_reset();
            DispReq = 1'b0;
         end
         if (!(DispReq && !m_last_gnt)) DispReq = ($urandom_range(0, 99) < 60);
         RelValid = 2'($urandom_range(0, 3));
         RelSlot0 = 5'($urandom_range(0, 31));
         RelSlot1 = 5'($urandom_range(0, 31));
         FlushReq = ($urandom_range(0, 99) < 3);
         cycle();
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/int_iq_slot_alloc_ctrl.md
Name: int_iq_slot_alloc_ctrl

Overview:
Sequences the 8-entry integer issue-queue slot free list: grants one slot per cycle to dispatch, and merges slot releases from two issue ports onto the free list's single push port with round-robin arbitration. Tracks outstanding allocations to guard against free-list overfill. Runs the flush/re-initialise handshake after a pipeline flush. Sits between dispatch, the int IQ issue ports and the slot free-list queue.

Parameters:
SLOTW, 5, slot index width (matches the free-list data width)
SLOTNUM, 8, number of allocatable slots (free-list depth)
SETTLE_CYC, 2, cycles dispatch is held off after the free-list clean

Ports:
Clk  in  1  clock
Rest  in  1  reset, asynchronous, active-high
DispReq  in  1  dispatch wants one IQ slot this cycle
DispGnt  out  1  slot granted this cycle (combinational)
DispSlot  out  SLOTW  granted slot index; valid when DispGnt=1
RelValid  in  2  per issue port: releasing a slot
RelSlot0  in  SLOTW  slot released by port 0
RelSlot1  in  SLOTW  slot released by port 1
RelReady  out  2  per port: release accepted this cycle
FlushReq  in  1  pipeline flush; 1-cycle pulse
FlRable  out  1  free-list pop strobe
FlWable  out  1  free-list push strobe
FlDin  out  SLOTW  free-list push data
FlClean  out  1  free-list re-initialise strobe
FlPreOut  in  SLOTW  free-list head entry
FlEmpty  in  1  free list empty
AllocCnt  out  4  slots currently allocated (0..SLOTNUM)
RelErr  out  1  sticky: a release arrived while AllocCnt would be exceeded

Behaviour:
- Reset (async, Rest=1): state RUN, AllocCnt=0, both hold buffers empty, round-robin pointer=port0, RelErr=0, settle counter=0. All strobes are 0 while in reset.
- FSM states:
  - RUN -> CLEAN on FlushReq.
  - CLEAN lasts 1 cycle; FlClean=1 -> SETTLE.
  - SETTLE counts SETTLE_CYC cycles -> RUN.
  - FlushReq in CLEAN or SETTLE restarts CLEAN.
- Dispatch grant: DispGnt = DispReq & state==RUN & !FlEmpty & !FlushReq.
  - DispSlot = FlPreOut; FlRable = DispGnt. Zero latency.
  - Dispatch must hold DispReq until granted.
- Release buffering:
  - Each port has a 1-entry hold buffer.
  - RelReady[i] = state==RUN & !FlushReq & (buffer i empty | buffer i drained this cycle).
  - Accepted data is written into buffer i on the next edge.
- Push arbitration: one push per cycle among non-empty buffers.
  - Round-robin; the pointer moves to the other port after each grant.
  - If only one buffer is valid, it wins regardless of the pointer.
  - FlWable=1, FlDin = winner's slot.
- Overfill guard: a push is allowed only if AllocCnt>0 after accounting for a same-cycle DispGnt.
  - Otherwise the winning buffer is discarded with no FlWable, and RelErr is set. RelErr clears only on reset.
- AllocCnt update: +1 on DispGnt, -1 on FlWable, unchanged if both occur in the same cycle.
  - AllocCnt never exceeds SLOTNUM, because FlEmpty blocks further grants.
- Simultaneous pop and push to the free list in the same cycle is legal and expected.
- Flush:
  - On the FlushReq cycle there is no grant, no accept, and no push.
  - Entering CLEAN empties both hold buffers (their pending releases are dropped) and sets AllocCnt=0.
  - The free list restores the full set of 8 slots on FlClean.
- The pointer retains its value across a flush.

Decomposition:
- Shared IQ package: SLOTW, SLOTNUM, FSM state encodings (RUN=0, CLEAN=1, SETTLE=2), and the free-list reset slot constants.
- One sub-module, rr_arb2: 2-requester round-robin arbiter with grant and pointer update.
- Hold buffers, counter and FSM live in the top level.

Test Plan:
- Reset, then DispReq=1 for 8 cycles with FlPreOut sequence 2,6,...,30 -> DispGnt=1 each cycle, AllocCnt 1..8. When FlEmpty=1 on the 9th cycle -> DispGnt=0.
- With AllocCnt=2, RelValid=2'b11 (slots 6, 14) in one cycle -> both RelReady=1. FlWable on two consecutive cycles: port0 (6) first, then port1 (14). AllocCnt ends at 0.
- Continuous releases on both ports with AllocCnt held high by dispatch -> pushes alternate port0, port1, port0. A same-cycle grant and push leaves AllocCnt unchanged.
- AllocCnt=0, RelValid[0] with slot 10 -> no FlWable, RelErr=1 and stays 1 until reset.
- FlushReq with one hold buffer full and AllocCnt=5 -> next cycle FlClean=1 and AllocCnt=0. DispGnt=0 for 1+SETTLE_CYC=3 cycles, then grants resume. The dropped release is never pushed.
- Assert Rest mid-SETTLE -> all outputs return to reset values immediately without waiting for a clock edge. On release, state is RUN.
